// File: rtl/forwarding_scoreboard_unit.sv
// -----------------------------------------------------------------------------
// forwarding_scoreboard_unit
// Tracks destination tags of the instructions sitting in the NUM_FWD_STAGES
// stages downstream of execute. It selects a forwarding source for each
// execute operand, and it raises a load-use stall when the youngest producer is
// a load whose data is not yet available.
// Optional feature: define FWD_PERF_EN to add saturating forward/stall
// performance counters. These are the perf_fwd_count and perf_stall_count
// ports.
// -----------------------------------------------------------------------------
module forwarding_scoreboard_unit #(
   parameter int NUM_FWD_STAGES   = 3,
   parameter int XLEN             = 32,
   parameter int LOAD_READY_STAGE = 2
) (
   input  logic                           CLK,
   input  logic                           RST,
   input  logic                           advance,
   input  logic                           flush,
   input  logic                           ex_valid,
   input  logic [4:0]                     ex_rd,
   input  logic                           ex_reg_write,
   input  logic                           ex_load,
   input  logic [4:0]                     rs1_e,
   input  logic [4:0]                     rs2_e,
   input  logic [XLEN-1:0]                rs1_rf,
   input  logic [XLEN-1:0]                rs2_rf,
   input  logic [NUM_FWD_STAGES*XLEN-1:0] stage_data,
   output logic [XLEN-1:0]                rs1_fwd,
   output logic [XLEN-1:0]                rs2_fwd,
   output logic [2:0]                     rs1_sel,
   output logic [2:0]                     rs2_sel,
   output logic                           stall
`ifdef FWD_PERF_EN
   ,
   output logic [31:0]                    perf_fwd_count,
   output logic [31:0]                    perf_stall_count
`endif
);

   // Scoreboard entries; index 0 holds entry 1 (youngest).
   logic [NUM_FWD_STAGES-1:0]      r_valid;
   logic [NUM_FWD_STAGES-1:0]      r_wr;
   logic [NUM_FWD_STAGES-1:0]      r_load;
   logic [NUM_FWD_STAGES-1:0][4:0] r_rd;

   // Per-operand resolution: bit 3 = load-use hazard, bits 2:0 = stage select.
   logic [3:0] w_res1;
   logic [3:0] w_res2;

   // Find the youngest producer of rs. Scanning from oldest to youngest lets
   // the youngest match overwrite any older one. A hit on a load that is not
   // yet forwardable reports a hazard with select 0, so the operand falls back
   // to the register file.
   function automatic logic [3:0] f_resolve(
      input logic [4:0]                     rs,
      input logic [NUM_FWD_STAGES-1:0]      valid,
      input logic [NUM_FWD_STAGES-1:0]      wr,
      input logic [NUM_FWD_STAGES-1:0]      load,
      input logic [NUM_FWD_STAGES-1:0][4:0] rd
   );
      logic [3:0] res;
      res = 4'd0;
      for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
         if ((rs != 5'd0) && valid[k] && wr[k] && (rd[k] != 5'd0) && (rd[k] == rs)) begin
            if (load[k] && ((k + 1) < LOAD_READY_STAGE)) begin
               res = {1'b1, 3'd0};
            end else begin
               res = {1'b0, 3'(k + 1)};
            end
         end
      end
      return res;
   endfunction

   // Scoreboard shift register: async reset, flush beats advance, bubble on stall.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_valid <= '0;
         r_wr    <= '0;
         r_load  <= '0;
         r_rd    <= '0;
      end else if (flush) begin
         r_valid <= '0;
      end else if (advance) begin
         for (int k = NUM_FWD_STAGES - 1; k > 0; k--) begin
            r_valid[k] <= r_valid[k-1];
            r_wr[k]    <= r_wr[k-1];
            r_load[k]  <= r_load[k-1];
            r_rd[k]    <= r_rd[k-1];
         end
         r_valid[0] <= ex_valid & ~stall;
         r_wr[0]    <= ex_reg_write;
         r_load[0]  <= ex_load;
         r_rd[0]    <= ex_rd;
      end
   end

   // Resolve both operands independently from the current entries.
   always_comb begin
      w_res1 = f_resolve(rs1_e, r_valid, r_wr, r_load, r_rd);
      w_res2 = f_resolve(rs2_e, r_valid, r_wr, r_load, r_rd);
   end

   // Operand select, forwarding mux and stall; stall only counts for a real instruction.
   always_comb begin
      rs1_sel = w_res1[2:0];
      rs2_sel = w_res2[2:0];
      stall   = ex_valid & (w_res1[3] | w_res2[3]);
      rs1_fwd = rs1_rf;
      rs2_fwd = rs2_rf;
      for (int k = 0; k < NUM_FWD_STAGES; k++) begin
         if (rs1_sel == 3'(k + 1)) begin
            rs1_fwd = stage_data[k*XLEN +: XLEN];
         end else begin
            rs1_fwd = rs1_fwd;
         end
         if (rs2_sel == 3'(k + 1)) begin
            rs2_fwd = stage_data[k*XLEN +: XLEN];
         end else begin
            rs2_fwd = rs2_fwd;
         end
      end
   end

`ifdef FWD_PERF_EN
   logic [31:0] r_perf_fwd;
   logic [31:0] r_perf_stall;
   logic        w_any_fwd;

   // Any operand taking a pipeline stage this cycle.
   always_comb begin
      w_any_fwd = (rs1_sel != 3'd0) || (rs2_sel != 3'd0);
   end

   // Saturating event counters.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_perf_fwd   <= 32'd0;
         r_perf_stall <= 32'd0;
      end else begin
         if (advance && w_any_fwd && (r_perf_fwd != 32'hFFFF_FFFF)) begin
            r_perf_fwd <= r_perf_fwd + 32'd1;
         end
         if (stall && (r_perf_stall != 32'hFFFF_FFFF)) begin
            r_perf_stall <= r_perf_stall + 32'd1;
         end
      end
   end

   assign perf_fwd_count   = r_perf_fwd;
   assign perf_stall_count = r_perf_stall;
`endif

endmodule

// File: tb/tb_forwarding_scoreboard_unit.sv
// -----------------------------------------------------------------------------
// tb_forwarding_scoreboard_unit
// Directed vectors with hand-computed expectations. The stimulus pushes the
// expected response into a queue. A monitor pops that queue on each falling
// edge and compares the expectation against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_forwarding_scoreboard_unit;
   localparam int NS = 3;
   localparam int XL = 32;

   logic             CLK;
   logic             RST;
   logic             advance, flush, ex_valid, ex_reg_write, ex_load;
   logic [4:0]       ex_rd, rs1_e, rs2_e;
   logic [XL-1:0]    rs1_rf, rs2_rf;
   logic [NS*XL-1:0] stage_data;
   logic [XL-1:0]    rs1_fwd, rs2_fwd;
   logic [2:0]       rs1_sel, rs2_sel;
   logic             stall;
`ifdef FWD_PERF_EN
   logic [31:0]      perf_fwd_count, perf_stall_count;
`endif

   typedef struct {
      string      name;
      logic [2:0] s1;
      logic [2:0] s2;
      logic       st;
      logic       chk_perf;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   forwarding_scoreboard_unit #(.NUM_FWD_STAGES(NS), .XLEN(XL), .LOAD_READY_STAGE(2)) dut (
      .CLK(CLK), .RST(RST), .advance(advance), .flush(flush),
      .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_load(ex_load),
      .rs1_e(rs1_e), .rs2_e(rs2_e), .rs1_rf(rs1_rf), .rs2_rf(rs2_rf),
      .stage_data(stage_data), .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd),
      .rs1_sel(rs1_sel), .rs2_sel(rs2_sel), .stall(stall)
`ifdef FWD_PERF_EN
      , .perf_fwd_count(perf_fwd_count), .perf_stall_count(perf_stall_count)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Expected operand for a given select, using the fixed stage data pattern.
   function automatic logic [XL-1:0] exp_fwd(input logic [2:0] sel, input logic [XL-1:0] rf);
      case (sel)
         3'd1:    return 32'hA1A1_0001;
         3'd2:    return 32'hB2B2_0002;
         3'd3:    return 32'hC3C3_0003;
         default: return rf;
      endcase
   endfunction

   // Monitor: pop one expectation per falling edge and compare.
   always @(negedge CLK) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         logic bad;
         e   = exp_q.pop_front();
         bad = (rs1_sel !== e.s1) || (rs2_sel !== e.s2) || (stall !== e.st) ||
               (rs1_fwd !== exp_fwd(e.s1, rs1_rf)) || (rs2_fwd !== exp_fwd(e.s2, rs2_rf));
`ifdef FWD_PERF_EN
         if (e.chk_perf && ((perf_fwd_count !== 32'd0) || (perf_stall_count !== 32'd0))) begin
            bad = 1'b1;
            $display("FAIL %s perf: fwd=%0d stall=%0d required 0/0", e.name, perf_fwd_count, perf_stall_count);
         end
`endif
         n_vec++;
         if (bad) begin
            n_miss++;
            $display("FAIL %s: got sel1=%0d sel2=%0d stall=%0d fwd1=%h fwd2=%h, required sel1=%0d sel2=%0d stall=%0d fwd1=%h fwd2=%h",
                     e.name, rs1_sel, rs2_sel, stall, rs1_fwd, rs2_fwd,
                     e.s1, e.s2, e.st, exp_fwd(e.s1, rs1_rf), exp_fwd(e.s2, rs2_rf));
         end
      end
   end

   // Apply one vector after a rising edge, optionally with an RST pulse between edges.
   task automatic vec(input string name, input logic rst_pulse,
                      input logic adv, input logic fl, input logic exv,
                      input logic [4:0] rd, input logic wr, input logic ld,
                      input logic [4:0] r1, input logic [4:0] r2,
                      input logic [2:0] s1, input logic [2:0] s2, input logic st,
                      input logic chk_perf);
      exp_t e;
      @(posedge CLK);
      #1;
      advance = adv; flush = fl; ex_valid = exv; ex_rd = rd;
      ex_reg_write = wr; ex_load = ld; rs1_e = r1; rs2_e = r2;
      if (rst_pulse) begin
         #1 RST = 1'b1;
      end
      e.name = name; e.s1 = s1; e.s2 = s2; e.st = st; e.chk_perf = chk_perf;
      exp_q.push_back(e);
      if (rst_pulse) begin
         @(negedge CLK);
         #1 RST = 1'b0;
      end
   endtask

   initial begin
      RST = 1'b1;
      advance = 1'b0; flush = 1'b0; ex_valid = 1'b0; ex_rd = 5'd0;
      ex_reg_write = 1'b0; ex_load = 1'b0; rs1_e = 5'd0; rs2_e = 5'd0;
      rs1_rf = 32'h1111_1111; rs2_rf = 32'h2222_2222;
      stage_data = {32'hC3C3_0003, 32'hB2B2_0002, 32'hA1A1_0001};

      //   name          rst  adv  fl   exv  rd     wr   ld   rs1    rs2    s1    s2    st   perf
      vec("in_reset",    1'b1,1'b0,1'b0,1'b0,5'd0, 1'b0,1'b0,5'd5, 5'd7, 3'd0, 3'd0, 1'b0,1'b1);
      vec("post_reset",  1'b0,1'b0,1'b0,1'b0,5'd0, 1'b0,1'b0,5'd0, 5'd0, 3'd0, 3'd0, 1'b0,1'b1);
      vec("add_x5",      1'b0,1'b1,1'b0,1'b1,5'd5, 1'b1,1'b0,5'd1, 5'd2, 3'd0, 3'd0, 1'b0,1'b0);
      vec("b2b_sub",     1'b0,1'b1,1'b0,1'b1,5'd6, 1'b1,1'b0,5'd5, 5'd6, 3'd1, 3'd0, 1'b0,1'b0);
      vec("issue_lw",    1'b0,1'b1,1'b0,1'b1,5'd7, 1'b1,1'b1,5'd5, 5'd6, 3'd2, 3'd1, 1'b0,1'b0);
      vec("load_use",    1'b0,1'b1,1'b0,1'b1,5'd8, 1'b1,1'b0,5'd5, 5'd7, 3'd3, 3'd0, 1'b1,1'b0);
      vec("after_bub",   1'b0,1'b1,1'b0,1'b1,5'd8, 1'b1,1'b0,5'd5, 5'd7, 3'd0, 3'd2, 1'b0,1'b0);
      vec("load_stg3",   1'b0,1'b1,1'b0,1'b1,5'd3, 1'b1,1'b0,5'd7, 5'd8, 3'd3, 3'd1, 1'b0,1'b0);
      vec("fill_x9",     1'b0,1'b1,1'b0,1'b1,5'd9, 1'b1,1'b0,5'd3, 5'd8, 3'd1, 3'd2, 1'b0,1'b0);
      vec("fill_x3b",    1'b0,1'b1,1'b0,1'b1,5'd3, 1'b1,1'b0,5'd3, 5'd9, 3'd2, 3'd1, 1'b0,1'b0);
      vec("youngest",    1'b0,1'b1,1'b0,1'b1,5'd0, 1'b1,1'b0,5'd3, 5'd0, 3'd1, 3'd0, 1'b0,1'b0);
      vec("x0_nomatch",  1'b0,1'b0,1'b0,1'b1,5'd0, 1'b1,1'b0,5'd0, 5'd9, 3'd0, 3'd3, 1'b0,1'b0);
      vec("flush_adv",   1'b0,1'b1,1'b1,1'b1,5'd9, 1'b1,1'b0,5'd3, 5'd0, 3'd2, 3'd0, 1'b0,1'b0);
      vec("post_flush",  1'b0,1'b0,1'b0,1'b1,5'd9, 1'b1,1'b0,5'd9, 5'd3, 3'd0, 3'd0, 1'b0,1'b0);
      vec("lw_again",    1'b0,1'b1,1'b0,1'b1,5'd7, 1'b1,1'b1,5'd0, 5'd0, 3'd0, 3'd0, 1'b0,1'b0);
      vec("exv_gate",    1'b0,1'b0,1'b0,1'b0,5'd0, 1'b0,1'b0,5'd0, 5'd7, 3'd0, 3'd0, 1'b0,1'b0);
      vec("stall_rs1",   1'b0,1'b0,1'b0,1'b1,5'd0, 1'b0,1'b0,5'd7, 5'd0, 3'd0, 3'd0, 1'b1,1'b0);
      vec("rst_midstl",  1'b1,1'b0,1'b0,1'b1,5'd0, 1'b0,1'b0,5'd7, 5'd0, 3'd0, 3'd0, 1'b0,1'b1);
      vec("empty_after", 1'b0,1'b0,1'b0,1'b1,5'd0, 1'b0,1'b0,5'd7, 5'd0, 3'd0, 3'd0, 1'b0,1'b1);

      repeat (3) @(negedge CLK);
      if (exp_q.size() != 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
